// File: rtl/rect_fill.sv
// Rectangle-fill engine driving the frame-buffer write port.
// Walks a latched rectangle row-major, one pixel per accepted write.
module rect_fill #(
    parameter int XW = 8,
    parameter int YW = 6,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] cmd_x0,
    input  logic [XW-1:0] cmd_x1,
    input  logic [YW-1:0] cmd_y0,
    input  logic [YW-1:0] cmd_y1,
    input  logic [CW-1:0] cmd_color,
    output logic          wr_en,
    input  logic          wr_ready,
    output logic [YW+XW-1:0] wr_addr,
    output logic [CW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FIN
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [XW-1:0] x;
    logic [XW-1:0] x0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y;
    logic [YW-1:0] y1;
    logic [CW-1:0] color;
    logic          err_q;

    logic accept;
    logic bad;
    logic step;
    logic last_x;
    logic last_y;

    assign accept = cmd_valid && (state == IDLE);
    assign bad    = (cmd_x0 > cmd_x1) || (cmd_y0 > cmd_y1);
    assign step   = (state == FILL) && wr_ready;
    assign last_x = (x == x1);
    assign last_y = (y == y1);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = bad ? FIN : FILL;
            FILL: if (step && last_x && last_y) state_nx = FIN;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The walk never passes x1/y1, so coordinates cannot wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            x     <= '0;
            x0    <= '0;
            x1    <= '0;
            y     <= '0;
            y1    <= '0;
            color <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            x     <= cmd_x0;
            x0    <= cmd_x0;
            x1    <= cmd_x1;
            y     <= cmd_y0;
            y1    <= cmd_y1;
            color <= cmd_color;
            err_q <= bad;
        end else if (step) begin
            if (!last_x) begin
                x <= x + 1'b1;
            end else if (!last_y) begin
                x <= x0;
                y <= y + 1'b1;
            end
        end
    end

    assign wr_addr = {y, x};
    assign wr_data = color;

    always_comb begin
        cmd_ready = 1'b0;
        wr_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        unique case (state)
            IDLE: cmd_ready = 1'b1;
            FILL: begin
                wr_en = 1'b1;
                busy  = 1'b1;
            end
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rect_fill.sv
// Directed bench for rect_fill: write order, back-pressure hold,
// invalid commands, full clear and reset abort.
module tb_rect_fill;

    localparam int XW = 8;
    localparam int YW = 6;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [XW-1:0] cmd_x0 = '0;
    logic [XW-1:0] cmd_x1 = '0;
    logic [YW-1:0] cmd_y0 = '0;
    logic [YW-1:0] cmd_y1 = '0;
    logic [CW-1:0] cmd_color = '0;
    logic          wr_en;
    logic          wr_ready = 1'b1;
    logic [YW+XW-1:0] wr_addr;
    logic [CW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          err;

    rect_fill #(.XW(XW), .YW(YW), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_x0   (cmd_x0),
        .cmd_x1   (cmd_x1),
        .cmd_y0   (cmd_y0),
        .cmd_y1   (cmd_y1),
        .cmd_color(cmd_color),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    int nwr;
    int n_en;
    int done_cyc;
    int order_err;
    int hold_err;
    logic err_seen;
    logic [31:0] first_a;
    logic [31:0] last_a;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [XW-1:0] a0,
                       input logic [XW-1:0] a1,
                       input logic [YW-1:0] b0,
                       input logic [YW-1:0] b1,
                       input logic [CW-1:0] c,
                       input bit bp,
                       input int abort_n);
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        logic [YW+XW-1:0] paddr;
        logic [CW-1:0] pdata;
        bit stall;
        bit fin;
        bit aborted;
        int cyc;
        int limit;
        nwr = 0; n_en = 0; done_cyc = 0;
        order_err = 0; hold_err = 0;
        err_seen = 0; first_a = '0; last_a = '0;
        @(negedge clk);
        check("rdy_pre", {31'd0, cmd_ready}, 32'd1);
        wr_ready  = 1'b1;
        cmd_x0    = a0;
        cmd_x1    = a1;
        cmd_y0    = b0;
        cmd_y1    = b1;
        cmd_color = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_x0    = ~a0;
        cmd_x1    = ~a1;
        cmd_y0    = ~b0;
        cmd_y1    = ~b1;
        cmd_color = ~c;
        ex = a0; ey = b0;
        stall = 0; fin = 0; aborted = 0;
        paddr = '0; pdata = '0;
        cyc = 1;
        limit = 3 * (int'(a1) + 1) * (int'(b1) + 1) + 20;
        while (cyc < limit) begin
            if (bp) wr_ready = (cyc % 3 == 1);
            if (stall && (wr_addr !== paddr
                || wr_data !== pdata)) hold_err++;
            if (wr_en) n_en++;
            if (done) begin
                done_cyc = cyc;
                err_seen = err;
                fin = 1;
                break;
            end
            if (wr_en && wr_ready) begin
                if (wr_addr !== {ey, ex} || wr_data !== c)
                    order_err++;
                if (nwr == 0) first_a = 32'(wr_addr);
                last_a = 32'(wr_addr);
                nwr++;
                if (ex != a1) begin
                    ex = ex + 1'b1;
                end else begin
                    ex = a0;
                    ey = ey + 1'b1;
                end
                if (abort_n != 0 && nwr == abort_n) begin
                    aborted = 1;
                    break;
                end
            end
            stall = wr_en && !wr_ready;
            paddr = wr_addr;
            pdata = wr_data;
            @(negedge clk);
            cyc++;
        end
        if (!fin && !aborted) check("timeout", 32'd0, 32'd1);
        if (fin) begin
            @(negedge clk);
            check("done_1cyc", {31'd0, done}, 32'd0);
            check("rdy_back", {31'd0, cmd_ready}, 32'd1);
        end
        wr_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rdy", {31'd0, cmd_ready}, 32'd1);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b1;

        // single pixel
        run(8'd5, 8'd5, 6'd3, 6'd3, 3'b101, 0, 0);
        check("px_nwr", nwr, 1);
        check("px_addr", first_a, 32'h0305);
        check("px_order", order_err, 0);
        check("px_done", done_cyc, 2);
        check("px_err", {31'd0, err_seen}, 32'd0);

        // 3x2 box
        run(8'd10, 8'd12, 6'd4, 6'd5, 3'b010, 0, 0);
        check("box_nwr", nwr, 6);
        check("box_en", n_en, 6);
        check("box_first", first_a, 32'h040A);
        check("box_last", last_a, 32'h050C);
        check("box_order", order_err, 0);
        check("box_done", done_cyc, 7);
        check("box_err", {31'd0, err_seen}, 32'd0);

        // same box under back-pressure 1,0,0,1,...
        run(8'd10, 8'd12, 6'd4, 6'd5, 3'b010, 1, 0);
        check("bp_nwr", nwr, 6);
        check("bp_en", n_en, 16);
        check("bp_order", order_err, 0);
        check("bp_hold", hold_err, 0);
        check("bp_last", last_a, 32'h050C);
        check("bp_done", done_cyc, 17);

        // invalid x and y ranges
        run(8'd20, 8'd19, 6'd1, 6'd2, 3'b111, 0, 0);
        check("inx_en", n_en, 0);
        check("inx_done", done_cyc, 1);
        check("inx_err", {31'd0, err_seen}, 32'd1);
        run(8'd1, 8'd2, 6'd9, 6'd8, 3'b111, 0, 0);
        check("iny_en", n_en, 0);
        check("iny_done", done_cyc, 1);
        check("iny_err", {31'd0, err_seen}, 32'd1);

        // full-screen clear
        run(8'd0, 8'd255, 6'd0, 6'd63, 3'b000, 0, 0);
        check("full_nwr", nwr, 16384);
        check("full_first", first_a, 32'h0000);
        check("full_last", last_a, 32'h3FFF);
        check("full_order", order_err, 0);
        check("full_done", done_cyc, 16385);

        // reset in the middle of a full clear
        run(8'd0, 8'd255, 6'd0, 6'd63, 3'b011, 0, 100);
        check("ab_nwr", nwr, 100);
        reset = 1'b0;
        @(negedge clk);
        check("ab_wr_en", {31'd0, wr_en}, 32'd0);
        check("ab_busy", {31'd0, busy}, 32'd0);
        check("ab_rdy", {31'd0, cmd_ready}, 32'd1);
        check("ab_done", {31'd0, done}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("ab_done2", {31'd0, done}, 32'd0);

        run(8'd255, 8'd255, 6'd62, 6'd63, 3'b110, 0, 0);
        check("post_nwr", nwr, 2);
        check("post_first", first_a, 32'h3EFF);
        check("post_last", last_a, 32'h3FFF);
        check("post_order", order_err, 0);
        check("post_done", done_cyc, 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rect_fill.md
# rect_fill

Rectangle-fill engine sitting upstream of the VGA frame-buffer memory: accepts one rectangle command at a time and writes its color into every covered pixel through the memory's write port. Scan-out (sync generators, memory read side) is unaffected; this block only owns the write side. It is used for screen clears, solid backgrounds and simple sprites/boxes.

## Interface

- XW, 8, column coordinate width (frame buffer row stride 2^XW)
- YW, 6, row coordinate width
- CW, 3, pixel color width ({red, green, blue})
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on rising clk, 0 = reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_x0, cmd_x1  in  XW  left / right column, inclusive
- cmd_y0, cmd_y1  in  YW  top / bottom row, inclusive
- cmd_color  in  CW  fill color
- wr_en  out  1  write request to frame buffer
- wr_ready  in  1  frame buffer accepts write this cycle
- wr_addr  out  YW+XW  write address = {y, x}, same packing as scan-out read address
- wr_data  out  CW  write color
- busy  out  1  command in progress (not IDLE)
- done  out  1  one-cycle pulse at command completion
- err  out  1  one-cycle pulse with done when command was invalid

## Operation

- States: IDLE, FILL, FIN.
- IDLE: cmd_ready=1, busy=0, wr_en=0. On cmd_valid && cmd_ready: latch x0, x1, y0, y1, color; set x=x0, y=y0.
  - If cmd_x0 > cmd_x1 or cmd_y0 > cmd_y1: go to FIN with error flag set; no writes issued.
  - Else go to FILL.
- FILL: wr_en=1, wr_addr={y,x}, wr_data=latched color. Coordinates advance only on wr_en && wr_ready:
  - x<x1: x=x+1.
  - x==x1, y<y1: x=x0, y=y+1.
  - x==x1, y==y1: last write accepted, go to FIN.
  - wr_ready=0: hold wr_addr/wr_data stable, wr_en stays 1 (no drop, no skip).
- FIN: done=1 for exactly one cycle, err=latched error flag, cmd_ready=0, wr_en=0; next state IDLE.
- Write order row-major, left to right, top to bottom; exactly (x1-x0+1)*(y1-y0+1) accepted writes, each pixel once.
- Coordinate arithmetic in XW/YW bits; comparisons unsigned; x never exceeds x1, so no wrap occurs. Full-range rectangle (0,0)-(2^XW-1,2^YW-1) is legal: 2^(XW+YW) writes.
- Commands presented while not in IDLE are ignored (cmd_ready=0); upstream holds cmd_valid.
- Inputs cmd_* are don't-care after the accept cycle.

## Timing

- Reset (reset=0 at a clock edge): state IDLE; outputs next cycle: cmd_ready=1, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0. Reset mid-FILL aborts immediately; partially filled pixels stay written; no done pulse.
- Accept at edge N -> first wr_en=1 visible after edge N (cycle N+1), addr {y0,x0}.
- With wr_ready tied 1: one pixel per cycle; last write accepted at cycle N+W (W = pixel count), done=1 in cycle N+W+1, cmd_ready=1 in cycle N+W+2.
- Invalid command accepted at edge N: done=err=1 in cycle N+1, cmd_ready=1 in cycle N+2.
- busy=1 in FILL and FIN.
- No combinational path from cmd_* or wr_ready to any output; all outputs registered or state-decoded.

## Test plan

- Single pixel: x0=x1=5, y0=y1=3, color 3'b101, wr_ready=1 -> one write, wr_addr 14'h0305, wr_data 3'b101; done one cycle after that write; cmd_ready back the cycle after done.
- 3x2 box x 10..12, y 4..5, color 3'b010 -> six writes in order 040A,040B,040C,050A,050B,050C; done pulse once; err=0.
- Back-pressure: same box, wr_ready toggling 1,0,0,1,... -> wr_addr/wr_data held during wr_ready=0 cycles, still exactly six accepted writes, same order.
- Invalid: x0=20, x1=19 -> zero wr_en cycles, done=err=1 one cycle after accept; also y0>y1 case.
- Full clear: 0..255 x 0..63, color 0, wr_ready=1 -> 16384 writes, first 0000, last 3FFF, done at accept+16385.
- Reset mid-fill: full clear, drive reset=0 after 100 writes -> wr_en=0, busy=0, cmd_ready=1 next cycle, no done; new command afterwards fills correctly.
